// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the GPU draw path: coordinate and colour field
// widths, the packed draw-command word (gpu_cmd_t), the opcode encoding and
// small helpers for packing and unpacking commands. The command queue itself
// only ever uses GPU_CMD_W and never looks inside the word.
// -----------------------------------------------------------------------------
package gpu_pkg;

    localparam int WIDTH_BITS   = 10;  // x coordinate width
    localparam int HEIGHT_BITS  = 10;  // y coordinate width
    localparam int CHANNEL_BITS = 8;   // per-channel colour width
    localparam int RADIUS_BITS  = 8;   // circle / arc radius width
    localparam int OPCODE_BITS  = 4;
    localparam int OCTANT_BITS  = 3;

    localparam int GPU_CMD_W = OCTANT_BITS + 3 * CHANNEL_BITS + RADIUS_BITS
                             + 2 * HEIGHT_BITS + 2 * WIDTH_BITS + OPCODE_BITS;

    typedef enum logic [OPCODE_BITS-1:0] {
        OP_NOP       = 4'd0,
        OP_PIXEL     = 4'd1,
        OP_LINE      = 4'd2,
        OP_RECT      = 4'd3,
        OP_FILL_RECT = 4'd4,
        OP_CIRCLE    = 4'd5,
        OP_ARC       = 4'd6,
        OP_CLEAR     = 4'd7
    } gpu_opcode_e;

    // Field order is MSB first; opcode sits in the low nibble.
    typedef struct packed {
        logic [OCTANT_BITS-1:0]  oct;
        logic [CHANNEL_BITS-1:0] b;
        logic [CHANNEL_BITS-1:0] g;
        logic [CHANNEL_BITS-1:0] r;
        logic [RADIUS_BITS-1:0]  rad;
        logic [HEIGHT_BITS-1:0]  y2;
        logic [WIDTH_BITS-1:0]   x2;
        logic [HEIGHT_BITS-1:0]  y1;
        logic [WIDTH_BITS-1:0]   x1;
        gpu_opcode_e             opcode;
    } gpu_cmd_t;

    // Flatten a command struct into the raw queue word.
    function automatic logic [GPU_CMD_W-1:0] gpu_cmd_pack(input gpu_cmd_t cmd);
        return cmd;
    endfunction

    // Recover a command struct from a raw queue word.
    function automatic gpu_cmd_t gpu_cmd_unpack(input logic [GPU_CMD_W-1:0] word);
        return gpu_cmd_t'(word);
    endfunction

endpackage

// File: rtl/gpu_cmd_queue_ctrl.sv
// -----------------------------------------------------------------------------
// gpu_cmd_queue_ctrl
// Bookkeeping for the command queue: read/write pointers, occupancy level,
// accept decisions for push and pop, status flags, high-water mark and the
// sticky overflow/underflow error flags. Storage lives in the parent.
//
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset
//   flush_i         synchronous clear of pointers and level (wins over push/pop)
//   push_i, pop_i   requests from producer / consumer
//   clear_err_i     clears the error flags and reloads the high-water mark
//   wr_en_o         storage write strobe (accepted push)
//   wr_ptr_o        storage write address
//   rd_ptr_o        storage read address (head entry)
//   empty_o, full_o, almost_full_o   decodes of the registered level
//   level_o         current occupancy
//   hwm_o           highest level reached since reset / flush / clear_err_i
//   overflow_o      sticky: push refused because the queue was full
//   underflow_o     sticky: pop requested while the queue was empty
// -----------------------------------------------------------------------------
module gpu_cmd_queue_ctrl #(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 1,
    parameter int PTR_W        = $clog2(DEPTH),
    parameter int LVL_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_err_i,
    output logic             wr_en_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             almost_full_o,
    output logic [LVL_W-1:0] level_o,
    output logic [LVL_W-1:0] hwm_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE   = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AFULL = LVL_W'(DEPTH - AFULL_MARGIN);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] hwm_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             push_ok_s;
    logic             pop_ok_s;
    logic             ovf_set_s;
    logic             udf_set_s;
    logic [LVL_W-1:0] level_next_s;
    logic [LVL_W-1:0] hwm_next_s;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic             overflow_next_s;
    logic             underflow_next_s;

    // Accept decisions and next occupancy; flush suppresses both requests.
    always_comb begin
        push_ok_s    = 1'b0;
        pop_ok_s     = 1'b0;
        ovf_set_s    = 1'b0;
        udf_set_s    = 1'b0;
        level_next_s = level_r;
        if (flush_i) begin
            level_next_s = LVL_ZERO;
        end else begin
            pop_ok_s  = pop_i & (level_r != LVL_ZERO);
            // A full queue still takes a push when a pop frees a slot this cycle.
            push_ok_s = push_i & ((level_r != LVL_FULL) | pop_ok_s);
            ovf_set_s = push_i & ~push_ok_s;
            udf_set_s = pop_i & (level_r == LVL_ZERO);
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_next_s = level_r + LVL_ONE;
                2'b01:   level_next_s = level_r - LVL_ONE;
                default: level_next_s = level_r;
            endcase
        end
    end

    // Pointer advance; both wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        if (flush_i) begin
            wr_ptr_next_s = PTR_ZERO;
            rd_ptr_next_s = PTR_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
        end
    end

    // High-water mark and sticky errors; a same-cycle set beats clear_err_i.
    always_comb begin
        hwm_next_s       = hwm_r;
        overflow_next_s  = ovf_set_s | (overflow_r  & ~clear_err_i);
        underflow_next_s = udf_set_s | (underflow_r & ~clear_err_i);
        if (flush_i) begin
            hwm_next_s = LVL_ZERO;
        end else if (clear_err_i) begin
            hwm_next_s = level_next_s;
        end else if (level_next_s > hwm_r) begin
            hwm_next_s = level_next_s;
        end else begin
            hwm_next_s = hwm_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            level_r     <= LVL_ZERO;
            hwm_r       <= LVL_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            level_r     <= level_next_s;
            hwm_r       <= hwm_next_s;
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
        end
    end

    assign wr_en_o       = push_ok_s;
    assign wr_ptr_o      = wr_ptr_r;
    assign rd_ptr_o      = rd_ptr_r;
    assign level_o       = level_r;
    assign hwm_o         = hwm_r;
    assign overflow_o    = overflow_r;
    assign underflow_o   = underflow_r;
    assign empty_o       = (level_r == LVL_ZERO);
    assign full_o        = (level_r == LVL_FULL);
    assign almost_full_o = (level_r >= LVL_AFULL);

endmodule

// File: rtl/gpu_cmd_queue.sv
// -----------------------------------------------------------------------------
// gpu_cmd_queue
// First-word-fall-through queue of packed draw commands between the APB
// register front end and the draw engine. The head entry is presented on
// data_o as soon as the queue is non-empty (one cycle after the first push).
//
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   flush_i           synchronous discard of all entries
//   push_i, data_i    enqueue a command word
//   pop_i             consume the head entry
//   data_o            head entry, meaningful only while empty_o = 0
//   empty_o, full_o   occupancy extremes
//   almost_full_o     level >= DEPTH - AFULL_MARGIN (interrupt back-pressure)
//   level_o, hwm_o    occupancy and high-water mark
//   overflow_o        sticky refused-push flag
//   underflow_o       sticky pop-while-empty flag
//   clear_err_i       clears the sticky flags and reloads hwm_o
// -----------------------------------------------------------------------------
module gpu_cmd_queue
    import gpu_pkg::*;
#(
    parameter int DATA_W       = GPU_CMD_W,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 1
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            data_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         almost_full_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic [$clog2(DEPTH+1)-1:0]   hwm_o,
    output logic                         overflow_o,
    output logic                         underflow_o,
    input  logic                         clear_err_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              wr_en_s;
    logic [PTR_W-1:0]  wr_ptr_s;
    logic [PTR_W-1:0]  rd_ptr_s;
    logic [DATA_W-1:0] mem_r [DEPTH];

    gpu_cmd_queue_ctrl #(
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN),
        .PTR_W        (PTR_W),
        .LVL_W        (LVL_W)
    ) u_ctrl (
        .clk           (clk),
        .n_rst         (n_rst),
        .flush_i       (flush_i),
        .push_i        (push_i),
        .pop_i         (pop_i),
        .clear_err_i   (clear_err_i),
        .wr_en_o       (wr_en_s),
        .wr_ptr_o      (wr_ptr_s),
        .rd_ptr_o      (rd_ptr_s),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .level_o       (level_o),
        .hwm_o         (hwm_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_s] <= data_i;
        end
    end

    // Head entry falls through from the read pointer.
    assign data_o = mem_r[rd_ptr_s];

endmodule

// File: tb/tb_gpu_cmd_queue.sv
module tb_gpu_cmd_queue;
    import gpu_pkg::*;

    localparam int DW    = GPU_CMD_W;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          flush_i = 1'b0;
    logic          push_i = 1'b0;
    logic          pop_i = 1'b0;
    logic          clear_err_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic [DW-1:0] data_o;
    logic          empty_o, full_o, almost_full_o, overflow_o, underflow_o;
    logic [LW-1:0] level_o, hwm_o;

    gpu_cmd_queue #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_MARGIN(1)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .flush_i       (flush_i),
        .push_i        (push_i),
        .data_i        (data_i),
        .pop_i         (pop_i),
        .data_o        (data_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .level_o       (level_o),
        .hwm_o         (hwm_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o),
        .clear_err_i   (clear_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          push, pop, flush, clr;
        logic [DW-1:0] din;
        int            lvl;
        logic          emp, ful, af, ov, un;
        int            hwm;
        logic [DW-1:0] head;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic pu, po, fl, cl, input logic [DW-1:0] d,
                                input int lvl, input logic emp, ful, af, ov, un,
                                input int hwm, input logic [DW-1:0] head);
        vec_t v;
        v.push = pu; v.pop = po; v.flush = fl; v.clr = cl; v.din = d;
        v.lvl = lvl; v.emp = emp; v.ful = ful; v.af = af; v.ov = ov; v.un = un;
        v.hwm = hwm; v.head = head;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int lvl, input logic emp, ful, af,
                               ov, un, input int hwm, input logic [DW-1:0] head);
        n_vec++;
        chk({tag, ".level"}, DW'(level_o), DW'(lvl));
        chk({tag, ".empty"}, DW'(empty_o), DW'(emp));
        chk({tag, ".full"},  DW'(full_o),  DW'(ful));
        chk({tag, ".afull"}, DW'(almost_full_o), DW'(af));
        chk({tag, ".ovf"},   DW'(overflow_o),  DW'(ov));
        chk({tag, ".udf"},   DW'(underflow_o), DW'(un));
        chk({tag, ".hwm"},   DW'(hwm_o), DW'(hwm));
        if (!emp) chk({tag, ".head"}, data_o, head);
    endtask

    task automatic drive(input logic pu, po, fl, cl, input logic [DW-1:0] d);
        @(negedge clk);
        push_i = pu; pop_i = po; flush_i = fl; clear_err_i = cl; data_i = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fill 1..8: almost_full from level 7, full at 8, head stays 0x01.
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1, 0, 0, 0, DW'(k), k, 0, (k == 8), (k >= 7), 0, 0, k, DW'(1)));
        // Push while full: refused, overflow set.
        vecs.push_back(mk(1, 0, 0, 0, DW'(9), 8, 0, 1, 1, 1, 0, 8, DW'(1)));
        // Push and pop while full: both accepted, level stays 8.
        vecs.push_back(mk(1, 1, 0, 0, DW'(10), 8, 0, 1, 1, 1, 0, 8, DW'(2)));
        // Drain 7: heads 3..8 then 0x0A.
        for (int j = 1; j <= 7; j++)
            vecs.push_back(mk(0, 1, 0, 0, DW'(0), 8 - j, 0, 0, ((8 - j) >= 7), 1, 0, 8,
                              (j <= 6) ? DW'(j + 2) : DW'(10)));
        vecs.push_back(mk(0, 1, 0, 0, DW'(0), 0, 1, 0, 0, 1, 0, 8, DW'(0)));
        // clear_err: overflow drops, hwm reloads with level 0.
        vecs.push_back(mk(0, 0, 0, 1, DW'(0), 0, 1, 0, 0, 0, 0, 0, DW'(0)));
        // Empty push+pop: push taken, pop ignored, underflow set.
        vecs.push_back(mk(1, 1, 0, 0, DW'(8'h55), 1, 0, 0, 0, 0, 1, 1, DW'(8'h55)));
        vecs.push_back(mk(0, 0, 0, 1, DW'(0), 1, 0, 0, 0, 0, 0, 1, DW'(8'h55)));
        vecs.push_back(mk(0, 1, 0, 0, DW'(0), 0, 1, 0, 0, 0, 0, 1, DW'(0)));
        // Pop-while-empty together with clear_err: set wins; hwm reloads to 0.
        vecs.push_back(mk(0, 1, 0, 1, DW'(0), 0, 1, 0, 0, 0, 1, 0, DW'(0)));
        vecs.push_back(mk(0, 0, 0, 1, DW'(0), 0, 1, 0, 0, 0, 0, 0, DW'(0)));
        // Load five, then flush with push and pop: nothing accepted, no flags.
        for (int k = 1; k <= 5; k++)
            vecs.push_back(mk(1, 0, 0, 0, DW'(8'h10 + k), k, 0, 0, 0, 0, 0, k, DW'(8'h11)));
        vecs.push_back(mk(1, 1, 1, 0, DW'(8'h99), 0, 1, 0, 0, 0, 0, 0, DW'(0)));
        vecs.push_back(mk(0, 0, 0, 0, DW'(0), 0, 1, 0, 0, 0, 0, 0, DW'(0)));

        // Reset state, sampled before the first clock edge.
        #3;
        check_state("reset", 0, 1, 0, 0, 0, 0, 0, DW'(0));
        @(negedge clk);
        n_rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].clr, vecs[i].din);
            check_state($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].emp, vecs[i].ful,
                        vecs[i].af, vecs[i].ov, vecs[i].un, vecs[i].hwm, vecs[i].head);
        end

        // Wrap: hold three entries and stream 20 push/pop pairs around the ring.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, DW'(8'hB0 + k));
            check_state($sformatf("wrap_fill%0d", k), k + 1, 0, 0, 0, 0, 0, k + 1, DW'(8'hB0));
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 0, DW'(8'hB3 + i));
            check_state($sformatf("wrap%0d", i), 3, 0, 0, 0, 0, 0, 3, DW'(8'hB1 + i));
        end

        // Asynchronous reset mid-burst at level 3, away from any clock edge.
        @(negedge clk);
        push_i = 1'b0; pop_i = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        check_state("async_rst", 0, 1, 0, 0, 0, 0, 0, DW'(0));
        n_rst = 1'b1;
        drive(1, 0, 0, 0, DW'(8'h77));
        check_state("post_rst_push", 1, 0, 0, 0, 0, 0, 1, DW'(8'h77));
        drive(0, 1, 0, 0, DW'(0));
        check_state("post_rst_pop", 0, 1, 0, 0, 0, 0, 1, DW'(0));
        drive(0, 0, 0, 0, DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
